// File: rtl/dds_cmd_ctrl.sv
// rtl/dds_cmd_ctrl.sv - UART byte command decoder producing DDS tuning word and waveform select (optional sweep: DDS_SWEEP_EN)
module dds_cmd_ctrl #(
    parameter int unsigned FW_K      = 5629500,
    parameter int unsigned SWEEP_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] freq_word,
    output logic [1:0]  wave_sel,
    output logic        upd,
    output logic        busy,
    output logic        err
);

    localparam logic [47:0] K48     = 48'(FW_K);
    localparam logic [31:0] FW_1KHZ = 32'd85899;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t       state, state_nxt;
    logic [23:0]  acc;
    logic [3:0]   dig_cnt;
    logic [23:0]  mcand;
    logic [47:0]  prod;
    logic [4:0]   bit_cnt;

    logic         is_digit, is_s, is_a, is_b, is_c, is_t, is_w, start_calc;
    logic [23:0]  acc_nxt;
    logic [47:0]  prod_nxt;

`ifdef DDS_SWEEP_EN
    localparam logic [31:0] DIV_M1 = 32'(SWEEP_DIV - 1);
    logic [31:0]  step;
    logic         sweep_on;
    logic [31:0]  presc;
    logic         tgt_step;
`endif

    // Byte classification and the combinational pieces of the datapath
    always_comb begin
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_s     = (rx_data == 8'h73);
        is_a     = (rx_data == 8'h61);
        is_b     = (rx_data == 8'h62);
        is_c     = (rx_data == 8'h63);
`ifdef DDS_SWEEP_EN
        is_t     = (rx_data == 8'h74);
        is_w     = (rx_data == 8'h77);
`else
        is_t     = 1'b0;
        is_w     = 1'b0;
`endif
        start_calc = rx_valid && (state == IDLE) && (is_s || is_t);
        // acc*10 + digit as (acc<<3)+(acc<<1)+digit, wrapping at 24 bits
        acc_nxt  = {acc[20:0], 3'b000} + {acc[22:0], 1'b0} + {20'd0, rx_data[3:0]};
        // one multiplicand bit per cycle, LSB first
        prod_nxt = prod + (mcand[0] ? (K48 << bit_cnt) : 48'd0);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and busy flag
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:   if (start_calc) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (bit_cnt == 5'd23) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: digit accumulator, shift-add multiplier, output registers and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 24'd0;
            dig_cnt   <= 4'd0;
            mcand     <= 24'd0;
            prod      <= 48'd0;
            bit_cnt   <= 5'd0;
            freq_word <= FW_1KHZ;
            wave_sel  <= 2'b00;
            upd       <= 1'b0;
            err       <= 1'b0;
`ifdef DDS_SWEEP_EN
            step      <= 32'd0;
            sweep_on  <= 1'b0;
            presc     <= 32'd0;
            tgt_step  <= 1'b0;
`endif
        end else begin
            upd <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
`ifdef DDS_SWEEP_EN
                    // sweep prescaler runs only while idle; 'w' below overrides it
                    if (sweep_on) begin
                        if (presc == DIV_M1) begin
                            presc     <= 32'd0;
                            freq_word <= freq_word + step;
                            upd       <= 1'b1;
                        end else begin
                            presc <= presc + 32'd1;
                        end
                    end
`endif
                    if (rx_valid) begin
                        if (is_digit) begin
                            if (dig_cnt == 4'd8) begin
                                err <= 1'b1;
                            end else begin
                                acc     <= acc_nxt;
                                dig_cnt <= dig_cnt + 4'd1;
                            end
                        end else if (is_s || is_t) begin
                            mcand   <= acc;
                            acc     <= 24'd0;
                            dig_cnt <= 4'd0;
                            prod    <= 48'd0;
                            bit_cnt <= 5'd0;
`ifdef DDS_SWEEP_EN
                            tgt_step <= is_t;
`endif
                        end else if (is_a) begin
                            wave_sel <= 2'b00;
                            upd      <= 1'b1;
                        end else if (is_c) begin
                            wave_sel <= 2'b01;
                            upd      <= 1'b1;
                        end else if (is_b) begin
                            wave_sel <= 2'b10;
                            upd      <= 1'b1;
                        end else if (is_w) begin
`ifdef DDS_SWEEP_EN
                            sweep_on <= ~sweep_on;
                            presc    <= 32'd0;
`endif
                        end else begin
                            acc     <= 24'd0;
                            dig_cnt <= 4'd0;
                            err     <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (rx_valid) err <= 1'b1;
                    prod    <= prod_nxt;
                    mcand   <= {1'b0, mcand[23:1]};
                    bit_cnt <= bit_cnt + 5'd1;
                    // last bit: register the result so it is visible during COMMIT
                    if (bit_cnt == 5'd23) begin
`ifdef DDS_SWEEP_EN
                        if (tgt_step) begin
                            step <= prod_nxt[47:16];
                        end else begin
                            freq_word <= prod_nxt[47:16];
                            upd       <= 1'b1;
                        end
`else
                        freq_word <= prod_nxt[47:16];
                        upd       <= 1'b1;
`endif
                    end
                end
                COMMIT: begin
                    if (rx_valid) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_cmd_ctrl.sv
// tb/tb_dds_cmd_ctrl.sv - scoreboard bench for dds_cmd_ctrl
module tb_dds_cmd_ctrl;

`ifdef DDS_SWEEP_EN
    localparam int unsigned SDIV = 4;
`else
    localparam int unsigned SDIV = 50000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] freq_word;
    logic [1:0]  wave_sel;
    logic        upd, busy, err;

    dds_cmd_ctrl #(.FW_K(5629500), .SWEEP_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .freq_word(freq_word), .wave_sel(wave_sel), .upd(upd), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] fw;
        logic [1:0]  ws;
    } upd_t;

    upd_t upd_q[$];
    int   err_q[$];
    int   tests = 0;
    int   fails = 0;
    int   last_n;
    logic [31:0] exp_fw;
    logic [1:0]  exp_ws;
    logic [31:0] step_exp;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fw_of(input longint unsigned hz);
        return 32'((hz * 64'd5629500) >> 16);
    endfunction

    // Monitor: every upd/err pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (upd === 1'b1) begin
                if (upd_q.size() == 0) begin
                    check("unexpected_upd", longint'(upd), 0);
                end else begin
                    upd_t e;
                    e = upd_q.pop_front();
                    check("upd_cycle", cyc, e.c);
                    check("upd_freq_word", freq_word, e.fw);
                    check("upd_wave_sel", wave_sel, e.ws);
                end
            end
            if (err === 1'b1) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err", longint'(err), 0);
                end else begin
                    int ec;
                    ec = err_q.pop_front();
                    check("err_cycle", cyc, ec);
                end
            end
        end
    end

    // One byte in the current cycle; expectations are queued before the edge
    task automatic send(input logic [7:0] b, input bit e_err, input bit e_upd);
        upd_t e;
        rx_data  = b;
        rx_valid = 1'b1;
        last_n   = cyc;
        if (e_err) err_q.push_back(cyc + 1);
        if (e_upd) begin
            e.c = cyc + 1; e.fw = exp_fw; e.ws = exp_ws;
            upd_q.push_back(e);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, 1'b0);
    endtask

    task automatic commit(input string digits, input logic [31:0] fw);
        upd_t e;
        send_str(digits);
        send("s", 1'b0, 1'b0);
        exp_fw = fw;
        e.c = last_n + 25; e.fw = exp_fw; e.ws = exp_ws;
        upd_q.push_back(e);
        repeat (25) @(negedge clk);
    endtask

`ifdef DDS_SWEEP_EN
    task automatic sweep_run(input int steps);
        upd_t e;
        int w;
        send("w", 1'b0, 1'b0);
        w = last_n;
        for (int k = 1; k <= steps; k++) begin
            exp_fw = exp_fw + step_exp;
            e.c = w + 1 + 4 * k; e.fw = exp_fw; e.ws = exp_ws;
            upd_q.push_back(e);
        end
        while (cyc < w + 1 + 4 * steps) @(negedge clk);
        send("w", 1'b0, 1'b0);
        repeat (12) @(negedge clk);
    endtask
`endif

    initial begin
        exp_fw = 32'd85899;
        exp_ws = 2'b00;
        step_exp = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_freq_word", freq_word, 85899);
        check("rst_wave_sel", wave_sel, 0);
        check("rst_upd", upd, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);

        // 1 kHz: busy window, bytes during CALC and COMMIT are rejected
        send_str("1000");
        check("busy_before_s", busy, 0);
        send("s", 1'b0, 1'b0);
        begin
            upd_t e;
            int n;
            n = last_n;
            e.c = n + 25; e.fw = 32'd85899; e.ws = 2'b00;
            upd_q.push_back(e);
            check("busy_n1", busy, 1);
            send("b", 1'b1, 1'b0);
            while (cyc < n + 24) @(negedge clk);
            check("busy_n24", busy, 1);
            @(negedge clk);
            check("busy_n25", busy, 0);
            send("a", 1'b1, 1'b0);
            check("wave_after_drop", wave_sel, 0);
        end
        exp_fw = 32'd85899;
        exp_ws = 2'b10;
        send("b", 1'b0, 1'b1);

        commit("2500000", 32'd214748382);

        // 9th digit rejected, first 8 kept
        send_str("12345678");
        send("9", 1'b1, 1'b0);
        commit("", fw_of(12345678));

        // unknown byte clears the accumulator
        send_str("12");
        send("x", 1'b1, 1'b0);
        commit("", 32'd0);

        exp_ws = 2'b01;
        send("c", 1'b0, 1'b1);
        exp_ws = 2'b00;
        send("a", 1'b0, 1'b1);

`ifdef DDS_SWEEP_EN
        send_str("100");
        send("t", 1'b0, 1'b0);
        repeat (26) @(negedge clk);
        step_exp = 32'd8589;
        sweep_run(3);
        send_str("16000000");
        send("t", 1'b0, 1'b0);
        repeat (26) @(negedge clk);
        step_exp = fw_of(16000000);
        sweep_run(4);
        check("sweep_wrapped", longint'(freq_word < step_exp), 1);
`else
        send("t", 1'b1, 1'b0);
        send("w", 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("tw_freq_unchanged", freq_word, 0);
`endif

        // reset in the middle of CALC: no commit afterwards
        send_str("5");
        send("s", 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_freq_word", freq_word, 85899);
        check("abort_wave_sel", wave_sel, 0);
        rst = 1'b0;
        exp_fw = 32'd85899;
        exp_ws = 2'b10;
        send("b", 1'b0, 1'b1);
        repeat (40) @(negedge clk);

        check("upd_queue_drained", upd_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
